// File: rtl/gl_raster_pkg.sv
// Shared definitions for the triangle rasterizer pipeline: state encoding,
// vertex/colour field positions and default widths.
package gl_raster_pkg;

   localparam int DEF_VERTEX_W       = 96;
   localparam int DEF_COLOR_W        = 96;
   localparam int DEF_CNT_W          = 16;
   localparam int DEF_SETTLE_CYCLES  = 2;
   localparam int DEF_TIMEOUT_CYCLES = 1048576;

   // IEEE-754 single fields inside the vertex and colour words
   localparam int VTX_X_MSB = 95;
   localparam int VTX_X_LSB = 64;
   localparam int VTX_Y_MSB = 63;
   localparam int VTX_Y_LSB = 32;
   localparam int COL_R_MSB = 95;
   localparam int COL_R_LSB = 64;
   localparam int COL_G_MSB = 63;
   localparam int COL_G_LSB = 32;
   localparam int COL_B_MSB = 31;
   localparam int COL_B_LSB = 0;

   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_SETTLE_ENC = 2'd1;
   localparam logic [1:0] ST_START_ENC  = 2'd2;
   localparam logic [1:0] ST_RUN_ENC    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_SETTLE = ST_SETTLE_ENC,
      ST_START  = ST_START_ENC,
      ST_RUN    = ST_RUN_ENC
   } sched_state_e;

endpackage

// File: rtl/gl_raster_sched_if.sv
// Upstream triangle bus: valid/ready handshake carrying three vertices and
// three colours from the geometry stage to the scheduler.
interface gl_raster_sched_if
   import gl_raster_pkg::*;
#(
   parameter int VERTEX_TYPE_SIZE = DEF_VERTEX_W,
   parameter int COLOR_TYPE_SIZE  = DEF_COLOR_W
);
   logic                        tri_valid;
   logic                        tri_ready;
   logic [VERTEX_TYPE_SIZE-1:0] tri_vertex1;
   logic [VERTEX_TYPE_SIZE-1:0] tri_vertex2;
   logic [VERTEX_TYPE_SIZE-1:0] tri_vertex3;
   logic [COLOR_TYPE_SIZE-1:0]  tri_color1;
   logic [COLOR_TYPE_SIZE-1:0]  tri_color2;
   logic [COLOR_TYPE_SIZE-1:0]  tri_color3;

   modport master (
      output tri_valid, tri_vertex1, tri_vertex2, tri_vertex3,
             tri_color1, tri_color2, tri_color3,
      input  tri_ready
   );

   modport slave (
      input  tri_valid, tri_vertex1, tri_vertex2, tri_vertex3,
             tri_color1, tri_color2, tri_color3,
      output tri_ready
   );
endinterface

// File: rtl/gl_sched_watchdog.sv
// RUN-state watchdog: counts while enabled, clears when told, and flags
// expiry once LIMIT cycles have elapsed.
module gl_sched_watchdog #(
   parameter int LIMIT = 1048576
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);
   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      expire = en && (cnt_q == W'(LIMIT - 1));
      cnt_d  = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !expire)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/gl_raster_sched.sv
// Triangle scheduler: latches one triangle, lets it settle, strobes the
// rasterizer and waits for done. Optional watchdog: GL_RASTER_SCHED_TIMEOUT_EN.
module gl_raster_sched
   import gl_raster_pkg::*;
#(
   parameter int VERTEX_TYPE_SIZE = DEF_VERTEX_W,
   parameter int COLOR_TYPE_SIZE  = DEF_COLOR_W,
   parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
   parameter int CNT_W            = DEF_CNT_W
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   gl_raster_sched_if.slave            tri_bus,
   output logic [VERTEX_TYPE_SIZE-1:0] vertex_out1,
   output logic [VERTEX_TYPE_SIZE-1:0] vertex_out2,
   output logic [VERTEX_TYPE_SIZE-1:0] vertex_out3,
   output logic [COLOR_TYPE_SIZE-1:0]  color_out1,
   output logic [COLOR_TYPE_SIZE-1:0]  color_out2,
   output logic [COLOR_TYPE_SIZE-1:0]  color_out3,
   output logic                        fifo_ready,
   input  logic                        raster_ready,
   output logic                        busy,
   output logic [CNT_W-1:0]            tri_count,
   output logic                        timeout_err
);
   sched_state_e                          state_q, state_d;
   logic [3:0]                            settle_cnt_q, settle_cnt_d;
   logic [2:0][VERTEX_TYPE_SIZE-1:0]      vertex_q, vertex_d;
   logic [2:0][COLOR_TYPE_SIZE-1:0]       color_q, color_d;
   logic                                  tri_ready_q, tri_ready_d;
   logic                                  fifo_ready_q, fifo_ready_d;
   logic                                  busy_q, busy_d;
   logic [CNT_W-1:0]                      tri_count_q, tri_count_d;

`ifdef GL_RASTER_SCHED_TIMEOUT_EN
   logic timeout_err_q, timeout_err_d;
   logic expire;

   gl_sched_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .en     (state_q == ST_RUN),
      .clr    (state_q != ST_RUN),
      .expire (expire)
   );

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      vertex_d     = vertex_q;
      color_d      = color_q;
      tri_count_d  = tri_count_q;
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // tri_ready_q gates acceptance so nothing is taken on the edge right after reset
            if (tri_bus.tri_valid && tri_ready_q) begin
               vertex_d     = {tri_bus.tri_vertex3, tri_bus.tri_vertex2, tri_bus.tri_vertex1};
               color_d      = {tri_bus.tri_color3, tri_bus.tri_color2, tri_bus.tri_color1};
               settle_cnt_d = 4'(SETTLE_CYCLES - 1);
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == 4'd0)
               state_d = ST_START;
            else
               settle_cnt_d = settle_cnt_q - 4'd1;
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            // a done pulse on the expiry cycle still counts as a completed triangle
            if (raster_ready) begin
               tri_count_d = tri_count_q + 1'b1;
               state_d     = ST_IDLE;
            end
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
            else if (expire) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      tri_ready_d  = (state_d == ST_IDLE);
      fifo_ready_d = (state_d == ST_START);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         vertex_q     <= '0;
         color_q      <= '0;
         tri_ready_q  <= 1'b0;
         fifo_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         tri_count_q  <= '0;
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         vertex_q     <= vertex_d;
         color_q      <= color_d;
         tri_ready_q  <= tri_ready_d;
         fifo_ready_q <= fifo_ready_d;
         busy_q       <= busy_d;
         tri_count_q  <= tri_count_d;
`ifdef GL_RASTER_SCHED_TIMEOUT_EN
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign tri_bus.tri_ready = tri_ready_q;
   assign fifo_ready        = fifo_ready_q;
   assign busy              = busy_q;
   assign tri_count         = tri_count_q;
   assign vertex_out1       = vertex_q[0];
   assign vertex_out2       = vertex_q[1];
   assign vertex_out3       = vertex_q[2];
   assign color_out1        = color_q[0];
   assign color_out2        = color_q[1];
   assign color_out3        = color_q[2];
endmodule

// File: doc/gl_raster_sched.md
# gl_raster_sched

Triangle scheduler that sequences the triangle rasterizer. It accepts one triangle at a time (three vertices and three colours) from the upstream triangle queue over a valid/ready handshake. It holds that triangle stable on the rasterizer's vertex/colour inputs, issues the one-cycle start strobe, and waits for the rasterizer's done pulse before accepting the next triangle. It sits between the geometry/transform stage and the rasterizer, and also keeps a completed-triangle count and an optional watchdog.

## Interface
- VERTEX_TYPE_SIZE, 96, vertex word width; x in [95:64], y in [63:32], IEEE-754 single.
- COLOR_TYPE_SIZE, 96, colour word width; r [95:64], g [63:32], b [31:0], IEEE-754 single.
- SETTLE_CYCLES, 2, cycles the latched triangle is held before the start strobe, so the rasterizer's combinational FP setup can settle; legal range 1..15.
- TIMEOUT_CYCLES, 1048576, watchdog limit in RUN; only used with the watchdog macro.
- CNT_W, 16, width of tri_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tri_valid  in  1  upstream triangle present.
- tri_ready  out  1  scheduler can accept a triangle.
- tri_vertex1/2/3  in  VERTEX_TYPE_SIZE  upstream vertices.
- tri_color1/2/3  in  COLOR_TYPE_SIZE  upstream colours.
- vertex_out1/2/3  out  VERTEX_TYPE_SIZE  to rasterizer vertex_in1..3.
- color_out1/2/3  out  COLOR_TYPE_SIZE  to rasterizer color_in1..3.
- fifo_ready  out  1  start strobe to the rasterizer.
- raster_ready  in  1  done pulse from the rasterizer.
- busy  out  1  high in any state except IDLE.
- tri_count  out  CNT_W  number of completed triangles; wraps.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, SETTLE, START, RUN.
- IDLE:
  - tri_ready=1.
  - On tri_valid&&tri_ready, register all six inputs into the out registers, load settle_cnt=SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE:
  - Outputs held.
  - Decrement settle_cnt; at 0 go to START.
- START:
  - fifo_ready=1 for exactly one cycle.
  - Go to RUN.
- RUN:
  - fifo_ready=0. Wait for raster_ready=1.
  - On raster_ready: tri_count+1 (modulo 2^CNT_W), go to IDLE.
- vertex_out/color_out change only on the accepting edge in IDLE. They are stable from the accept edge until the next accept.
- raster_ready is ignored outside RUN and has no effect there.
- Reset mid-operation: everything returns to reset values immediately, and the in-flight triangle is dropped. The rasterizer has no reset of its own, so system integration must reset both together.
- tri_count wraps from 2^CNT_W-1 to 0 without any flag.

## Timing
- Reset values:
  - tri_ready=0 during reset, 1 on the first cycle after reset release.
  - fifo_ready=0, busy=0, tri_count=0, timeout_err=0.
  - All vertex_out/color_out=0.
  - State is IDLE.
- Accept edge T (in IDLE) → SETTLE for cycles T+1..T+SETTLE_CYCLES → fifo_ready high in cycle T+SETTLE_CYCLES+1.
- Done: raster_ready sampled high at edge D → tri_count updates at D, and tri_ready=1 in cycle D+1.
- Minimum triangle-to-triangle start spacing is SETTLE_CYCLES+3 cycles plus the rasterizer run time.
- tri_ready is a registered state decode with no combinational path from tri_valid.

## Configuration
- GL_RASTER_SCHED_TIMEOUT_EN:
  - Defined: a RUN-state counter resets on entry to RUN. If it reaches TIMEOUT_CYCLES without raster_ready, timeout_err is set (sticky until rst), the state goes to IDLE, and tri_count is not incremented.
  - Undefined: RUN waits indefinitely, timeout_err is tied 0, and no counter logic exists.

## Structure
- Shared package gl_raster_pkg holds:
  - the state encoding localparams (IDLE=0, SETTLE=1, START=2, RUN=3);
  - the VERTEX/COLOR field bit positions;
  - the default widths.
  - The rasterizer and future pipeline stages use the same package.
- One sub-module, gl_sched_watchdog (enable/clear/expire counter), instantiated only under GL_RASTER_SCHED_TIMEOUT_EN.

## Test plan
- Reset then idle: assert rst mid-cycle → all outputs 0 asynchronously; after release, tri_ready=1, busy=0, tri_count=0.
- Single triangle, SETTLE_CYCLES=2: tri_valid at edge 10 → fifo_ready high only in cycle 13. raster_ready pulse at edge 40 → tri_count=1, tri_ready=1 in cycle 41. vertex_out equals the inputs captured at edge 10 throughout.
- Back-to-back: tri_valid held high with 3 distinct triangles, stub rasterizer done 20 cycles after each start → 3 starts, each with correct held vertices, tri_count=3, no triangle accepted while busy=1.
- Spurious done: raster_ready pulses in IDLE and in SETTLE → no state change, tri_count unchanged.
- Count wrap: CNT_W=4, 17 triangles → tri_count=1.
- Watchdog (macro defined, TIMEOUT_CYCLES=50): no raster_ready → timeout_err=1 fifty cycles after entering RUN, state IDLE, tri_count unchanged. Flag persists until rst.
